// File: rtl/proc_injector_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : proc_injector_if
// Purpose  : Bundles the two channels of the processor injector.
//            Processor side : in_valid / in_ready / in_dest / in_payload
//                             (clocked valid/ready, accept on valid && ready)
//            Router side    : out_req / out_data / out_ack
//                             (two-phase toggle, bundled data; ack async)
// Modports : slave  - the injector (consumes payloads, drives the router)
//            master - the environment (processor + router)
// Revision : 1.0 - initial release
// ============================================================================
interface proc_injector_if #(
  parameter int N = 32
);
  // processor-side valid/ready channel
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_dest;
  logic [N-5:0]   in_payload;

  // router-side two-phase bundled-data channel
  logic           out_req;
  logic [N-1:0]   out_data;
  logic           out_ack;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_dest,
    input  in_payload,
    output out_req,
    output out_data,
    input  out_ack
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_dest,
    output in_payload,
    input  out_req,
    input  out_data,
    output out_ack
  );
endinterface
`default_nettype wire

// File: rtl/proc_injector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : proc_injector
// Purpose  : Network interface feeding the processor input port of a mesh
//            router. Payloads from a clocked valid/ready source are formed
//            into routing flits {dst_x, dst_y, dx, dy, payload}, buffered in
//            a small FIFO and sent one at a time over a two-phase (toggle)
//            req/ack bundled-data channel. The router's ack is asynchronous
//            and is brought in through a SYNC_STAGES-deep synchroniser.
//
// Ports    : clk        - single clock
//            rst        - synchronous, active-low reset
//            bus        - proc_injector_if.slave
//                           in_valid/in_ready/in_dest/in_payload (processor)
//                           out_req/out_data/out_ack             (router)
//            sent_count - completed transfers, wraps at 16 bits (registered)
//            drop_pulse - one-cycle pulse per discarded self-addressed
//                         payload (registered)
//            busy       - FIFO non-empty or FSM not idle (combinational)
//
// Revision : 1.0 - initial release
// ============================================================================
module proc_injector #(
  parameter int N           = 32,
  parameter int SRCX        = 0,
  parameter int SRCY        = 0,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  proc_injector_if.slave     bus,
  output logic [15:0]        sent_count,
  output logic               drop_pulse,
  output logic               busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int        AW      = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = DEPTH[AW:0];
  localparam logic      c_srcx  = (SRCX != 0);
  localparam logic      c_srcy  = (SRCY != 0);

  // --------------------------------------------------------------------------
  // FSM encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // waiting for a flit in the FIFO
    ST_LOAD     = 2'd1,  // out_data loaded; req toggles on the next edge
    ST_WAIT_ACK = 2'd2   // req issued; holding data until ack matches req
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Storage and registered outputs
  // --------------------------------------------------------------------------
  logic [N-1:0]          r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;

  logic [SYNC_STAGES-1:0] r_sync;

  logic [N-1:0]          r_out_data;
  logic                  r_out_req;
  logic [15:0]           r_sent_count;
  logic                  r_drop;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_self;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_toggle;
  logic                  w_done;
  logic                  w_fifo_nempty;
  logic                  w_ack_s;
  logic                  w_dx;
  logic                  w_dy;
  logic [N-1:0]          w_flit;

  // Ready depends on the current count only: a full FIFO refuses a push even
  // when a pop happens on the same edge. This keeps in_ready free of any
  // combinational path from the FSM.
  assign w_in_ready    = (r_count < c_depth);
  assign w_accept      = bus.in_valid && w_in_ready;

  // A payload addressed to this node is accepted (handshake completes) but
  // never enters the FIFO.
  assign w_self        = (bus.in_dest == {c_srcx, c_srcy});
  assign w_push        = w_accept && !w_self;

  assign w_fifo_nempty = (r_count != '0);

  // Single-bit coordinates: "dst > src" reduces to dst=1, src=0.
  assign w_dx          = bus.in_dest[1] & ~c_srcx;
  assign w_dy          = bus.in_dest[0] & ~c_srcy;

  // Deltas are resolved at push time so the FIFO holds complete flits.
  assign w_flit        = {bus.in_dest, w_dx, w_dy, bus.in_payload};

  assign w_ack_s       = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Ack synchroniser: out_ack is asynchronous to clk. Each stage is a plain
  // flop; only the last stage is used by the FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.out_ack};
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. Contents need no reset; emptiness is tracked by the
  // pointers and count below.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wptr] <= w_flit;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_toggle    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // out_data has been stable for a full cycle when req flips, which
        // gives the bundled-data setup margin at the router.
        w_toggle    = 1'b1;
        w_state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Two-phase protocol: the transfer is complete once the synchronised
        // ack has caught up with req, regardless of the level.
        if (w_ack_s == r_out_req) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Router channel and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_data   <= '0;
      r_out_req    <= 1'b0;
      r_sent_count <= '0;
      r_drop       <= 1'b0;
    end else begin
      if (w_pop) begin
        r_out_data <= r_mem[r_rptr];
      end
      if (w_toggle) begin
        r_out_req <= ~r_out_req;
      end
      if (w_done) begin
        r_sent_count <= r_sent_count + 16'd1;
      end
      r_drop <= w_accept && w_self;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready = w_in_ready;
  assign bus.out_req  = r_out_req;
  assign bus.out_data = r_out_data;
  assign sent_count   = r_sent_count;
  assign drop_pulse   = r_drop;
  assign busy         = w_fifo_nempty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_proc_injector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_proc_injector
// Purpose  : Directed self-checking bench for proc_injector (N=32, node
//            (0,0), DEPTH=4, SYNC_STAGES=2). A router model echoes req onto
//            ack a programmable number of cycles later, toggling on the
//            falling edge so the ack arrives between two rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_injector;

  localparam int N  = 32;
  localparam int SS = 2;

  logic        clk;
  logic        rst;
  logic [15:0] sent_count;
  logic        drop_pulse;
  logic        busy;

  int          checks;
  int          errors;

  // router model controls
  logic        ack_en;
  logic        router_rst;
  int          ack_delay;

  proc_injector_if #(.N(N)) bus ();

  proc_injector #(
    .N           (N),
    .SRCX        (0),
    .SRCY        (0),
    .DEPTH       (4),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sent_count (sent_count),
    .drop_pulse (drop_pulse),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Router model: when enabled, copies req onto ack ack_delay falling edges
  // after it sees them differ.
  initial begin : router_model
    int cnt;
    cnt = 0;
    bus.out_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (router_rst) begin
        bus.out_ack = 1'b0;
        cnt = 0;
      end else if (ack_en && (bus.out_req !== bus.out_ack)) begin
        cnt = cnt + 1;
        if (cnt >= ack_delay) begin
          bus.out_ack = bus.out_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    router_rst     = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_dest    = 2'b00;
    bus.in_payload = '0;
    repeat (3) tick();
    rst        = 1'b1;
    router_rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    ack_en = 1'b0;
    do_reset();
    checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL reset_out_req: got %b want 0", bus.out_req); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL reset_sent_count: got %0d want 0", sent_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_flit();
    int n;
    ack_en    = 1'b1;
    ack_delay = 3;
    bus.in_valid   = 1'b1;
    bus.in_dest    = 2'b11;
    bus.in_payload = 28'hFFFFFFE;
    tick();                                    // edge k: accept
    bus.in_valid = 1'b0;
    checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL single_req_k: got %b want 0", bus.out_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k: got %b want 1", busy); end
    tick();                                    // edge k+1: pop
    checks++; if (bus.out_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL single_data_k1: got %h want fffffffe", bus.out_data); end
    checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL single_req_k1: got %b want 0", bus.out_req); end
    tick();                                    // edge k+2: req toggles
    checks++; if (bus.out_req !== 1'b1) begin errors++; $display("FAIL single_req_k2: got %b want 1", bus.out_req); end
    // wait for the ack to arrive; the edge just passed is j
    n = 0;
    while ((bus.out_ack !== bus.out_req) && (n < 20)) begin
      tick();
      n++;
    end
    checks++;
    if (bus.out_ack !== bus.out_req) begin
      errors++; $display("FAIL single_ack_timeout: ack %b want %b", bus.out_ack, bus.out_req);
    end else begin
      checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL single_cnt_j: got %0d want 0", sent_count); end
      tick();                                  // j+1
      checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL single_cnt_j1: got %0d want 0", sent_count); end
      tick();                                  // j+SYNC_STAGES
      checks++; if (sent_count !== 16'd1) begin errors++; $display("FAIL single_cnt_j2: got %0d want 1", sent_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_deltas();
    logic [1:0]  dests [2];
    logic [31:0] exp   [2];
    logic        prev_req;
    logic [15:0] prev_cnt;
    int          n;
    dests[0] = 2'b01; exp[0] = 32'h50000123;
    dests[1] = 2'b10; exp[1] = 32'hA0000123;
    ack_en    = 1'b1;
    ack_delay = 2;
    for (int v = 0; v < 2; v++) begin
      prev_req = bus.out_req;
      prev_cnt = sent_count;
      bus.in_valid   = 1'b1;
      bus.in_dest    = dests[v];
      bus.in_payload = 28'h0000123;
      tick();
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.out_data !== exp[v]) begin errors++; $display("FAIL delta%0d_data: got %h want %h", v, bus.out_data, exp[v]); end
      tick();
      checks++; if (bus.out_req !== ~prev_req) begin errors++; $display("FAIL delta%0d_req: got %b want %b", v, bus.out_req, ~prev_req); end
      n = 0;
      while ((sent_count === prev_cnt) && (n < 30)) begin
        tick();
        n++;
      end
      checks++; if (sent_count !== prev_cnt + 16'd1) begin errors++; $display("FAIL delta%0d_sent: got %0d want %0d", v, sent_count, prev_cnt + 16'd1); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_pressure();
    int          n;
    int          idx;
    logic        was_ready;
    logic [15:0] last_cnt;
    do_reset();
    ack_en = 1'b0;
    bus.in_dest = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_payload = 28'(i);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_push%0d: got %b want 1", i, bus.in_ready); end
      tick();
    end
    bus.in_payload = 28'd6;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_data !== 32'hF0000001) begin errors++; $display("FAIL bp_head: got %h want f0000001", bus.out_data); end
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: in_ready got %b want 0", bus.in_ready); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL bp_frozen_cnt: got %0d want 0", sent_count); end

    ack_en    = 1'b1;
    ack_delay = 1;
    idx       = 0;
    last_cnt  = sent_count;
    n         = 0;
    while ((idx < 6) && (n < 300)) begin
      was_ready = bus.in_ready;
      tick();
      n++;
      if (bus.in_valid && was_ready) bus.in_valid = 1'b0;
      if (sent_count !== last_cnt) begin
        idx++;
        last_cnt = sent_count;
        checks++;
        if (bus.out_data !== (32'hF0000000 | 32'(idx))) begin
          errors++; $display("FAIL bp_order%0d: got %h want %h", idx, bus.out_data, 32'hF0000000 | 32'(idx));
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (sent_count !== 16'd6) begin errors++; $display("FAIL bp_total: got %0d want 6", sent_count); end
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drained_busy: got %b want 0", busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_self_addressed();
    int busy_seen;
    int drops;
    do_reset();
    ack_en    = 1'b1;
    ack_delay = 1;
    bus.in_valid   = 1'b1;
    bus.in_dest    = 2'b00;
    bus.in_payload = 28'hABCDEF0;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL self_drop: got %b want 1", drop_pulse); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL self_busy_k: got %b want 0", busy); end
    busy_seen = 0;
    drops     = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
      if (drop_pulse !== 1'b0) drops++;
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL self_drop_len: extra high cycles %0d want 0", drops); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL self_busy: busy cycles %0d want 0", busy_seen); end
    checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL self_req: got %b want 0", bus.out_req); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL self_sent: got %0d want 0", sent_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_transfer();
    int n;
    do_reset();
    ack_en = 1'b0;
    bus.in_dest = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_payload = 28'h11 * 28'(i + 1);
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while ((bus.out_req !== 1'b1) && (n < 10)) begin
      tick();
      n++;
    end
    checks++; if (bus.out_req !== 1'b1) begin errors++; $display("FAIL mid_wait_req: got %b want 1", bus.out_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end

    rst        = 1'b0;
    router_rst = 1'b1;
    repeat (3) tick();
    rst        = 1'b1;
    router_rst = 1'b0;
    checks++; if (bus.out_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", bus.out_req); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 00000000", bus.out_data); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL mid_rst_sent: got %0d want 0", sent_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    repeat (4) tick();
    checks++; if ((busy !== 1'b0) || (bus.out_req !== 1'b0)) begin errors++; $display("FAIL mid_fifo_empty: busy %b req %b want 0 0", busy, bus.out_req); end

    ack_en    = 1'b1;
    ack_delay = 2;
    bus.in_valid   = 1'b1;
    bus.in_dest    = 2'b10;
    bus.in_payload = 28'h0000044;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while ((sent_count === 16'd0) && (n < 30)) begin
      tick();
      n++;
    end
    checks++; if (sent_count !== 16'd1) begin errors++; $display("FAIL mid_after_sent: got %0d want 1", sent_count); end
    checks++; if (bus.out_data !== 32'hA0000044) begin errors++; $display("FAIL mid_after_data: got %h want a0000044", bus.out_data); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    ack_en         = 1'b0;
    router_rst     = 1'b1;
    ack_delay      = 3;
    bus.in_valid   = 1'b0;
    bus.in_dest    = 2'b00;
    bus.in_payload = '0;

    test_reset();
    test_single_flit();
    test_deltas();
    test_back_pressure();
    test_self_addressed();
    test_reset_mid_transfer();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_injector.md
# proc_injector

Synchronous network interface that feeds the processor input port of a mesh router. It accepts payloads from a clocked processor-side valid/ready interface and buffers them in a small FIFO. Each payload is formed into a routing flit `{dest, deltas, payload}` with deltas computed from this node's coordinates, and sent over the router's two-phase (toggle) req/ack bundled-data channel. The returning ack is synchronised into the clock domain.

## Interface
- `N`, 32: flit width; payload width is N-4.
- `SRCX`, 0: this node's x coordinate (0 or 1).
- `SRCY`, 0: this node's y coordinate (0 or 1).
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `SYNC_STAGES`, 2: flops in the ack synchroniser, ≥2.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  processor offers a payload.
- `in_ready`  out  1  FIFO can accept a payload.
- `in_dest`  in  2  destination `{dst_x, dst_y}`.
- `in_payload`  in  N-4  payload bits.
- `out_req`  out  1  toggle request to router `proc_input.req`.
- `out_data`  out  N  flit to router `proc_input.data`.
- `out_ack`  in  1  toggle acknowledge from router `proc_input.ack` (asynchronous).
- `sent_count`  out  16  completed transfers, wraps.
- `drop_pulse`  out  1  one-cycle pulse for each rejected self-addressed payload.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Flit format: `out_data = {dst_x, dst_y, dx, dy, payload}`.
  - dx = (dst_x > SRCX).
  - dy = (dst_y > SRCY).
- Accept:
  - A payload is accepted on a rising edge when `in_valid && in_ready`.
  - `in_ready` = FIFO count < DEPTH. It is based on the current count only, so a push is refused while full even if a pop happens on the same edge.
- Self-addressed payload (`in_dest == {SRCX, SRCY}`):
  - It is accepted and discarded, and not written to the FIFO.
  - `drop_pulse` goes high for the one cycle after the accept edge.
- The flit (including deltas) is formed at push time and stored in the FIFO.
- Ack synchroniser: `SYNC_STAGES` flops; the last flop output is `ack_s`.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the `out_data` register and go to LOAD.
  - LOAD: toggle `out_req` and go to WAIT_ACK. `out_data` has therefore been stable for one full cycle before the req edge (bundled-data setup).
  - WAIT_ACK: `out_data` and `out_req` are held. When `ack_s == out_req`, increment `sent_count` and go to IDLE.
- Ordering: strict FIFO order; no flit is lost or duplicated.
- `sent_count` wraps from 16'hFFFF to 0.
- Reset (synchronous, `rst == 0` at an edge):
  - Values: `out_req` = 0, `out_data` = 0, sync flops = 0, FIFO emptied, state = IDLE, `sent_count` = 0, `drop_pulse` = 0, `busy` = 0.
  - `in_ready` = 1 from the first cycle after reset.
  - Reset in WAIT_ACK abandons the transfer without waiting for ack. The router must be reset in the same window.

## Timing
- Empty FIFO, FSM in IDLE, payload accepted at edge k:
  - FIFO becomes non-empty after edge k.
  - `out_data` is updated at edge k+1 (IDLE→LOAD).
  - `out_req` toggles at edge k+2 (LOAD→WAIT_ACK).
- Router toggles `out_ack` between edges j-1 and j:
  - `ack_s` matches after edge j+SYNC_STAGES-1.
  - The FSM leaves WAIT_ACK and `sent_count` increments at edge j+SYNC_STAGES.
- Back-to-back flits: the next pop happens at the edge after returning to IDLE, so the minimum is SYNC_STAGES+3 cycles per flit plus router delay.
- `in_ready` deasserts in the cycle after the edge that fills the FIFO, and reasserts in the cycle after the LOAD pop.
- `drop_pulse` and `sent_count` are registered outputs.
- `busy` is combinational from state and FIFO count.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles. Expect `out_req` = 0, `out_data` = 32'h0, `in_ready` = 1, `sent_count` = 0, `busy` = 0 and `drop_pulse` = 0.
- Single flit, SRCX = SRCY = 0: `in_dest` = 2'b11, payload 28'hFFFFFFE.
  - `out_data` = 32'hFFFFFFFE at k+1 and `out_req` goes 0→1 at k+2.
  - The bench echoes ack after 3 cycles; `sent_count` = 1 exactly SYNC_STAGES edges after the ack toggle.
- Delta encoding:
  - dest 2'b01, payload 28'h0000123 → 32'h50000123.
  - dest 2'b10, same payload → 32'hA0000123.
  - Each is sent with a fresh `out_req` toggle (1→0, then 0→1).
- Backpressure with DEPTH = 4 and `out_ack` frozen:
  - Push payloads 1..6. Payload 1 goes to `out_data`; 2..5 fill the FIFO; `in_ready` = 0 and payload 6 is stalled.
  - Release ack: all six arrive in order 1..6 and `sent_count` = 6.
- Self-addressed: dest 2'b00 → one `drop_pulse` cycle, no `out_req` toggle, `sent_count` unchanged, `busy` stays 0.
- Reset mid-transfer: assert reset in WAIT_ACK with 2 flits queued. Expect all reset values, FIFO empty, and a subsequent single flit to transfer normally with `sent_count` = 1.
